mmio_uart_bridge: RTL and testbench

- Memory-mapped I/O back end. It sits downstream of the pipeline controller and consumes its EX-stage MMIO select and store data.
- It owns the UART TX/RX buffering, the cycle counter and the retired-instruction counter.
- It returns registered read data that is aligned with the MEM/WB stage, where the writeback mux selects it.

---
 rtl/mmio_uart_bridge.sv | 185 ++++++++++++++++++
 tb/tb_mmio_uart_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_bridge.sv
// -----------------------------------------------------------------------------
// mmio_uart_bridge
//
// Memory-mapped I/O back end for the core pipeline. It takes the EX-stage MMIO
// select and store data. It buffers UART traffic in a TX FIFO and an RX FIFO,
// keeps a free-running cycle counter and a retired-instruction counter, and
// returns registered read data that lines up with the MEM/WB stage.
//
// Ports
//   clk            core clock, rising-edge
//   rst            asynchronous reset, active low
//   mmap_sel       EX-stage select: 0 CTRL rd, 1 RX rd, 2 TX wr, 3 cycle rd,
//                  4 instr rd, 5 counter clear, 6/7 idle
//   wdata          EX-stage store data; [7:0] is the TX byte
//   inst_retire    one real instruction leaves MEM/WB this cycle
//   mmio_rdata     registered read data (1-cycle latency)
//   uart_tx_data   head of TX FIFO (0 when empty)
//   uart_tx_valid  TX FIFO not empty
//   uart_tx_ready  UART transmitter takes the head byte
//   uart_rx_data   byte from the UART receiver
//   uart_rx_valid  receiver byte valid
//   uart_rx_ready  RX FIFO not full
// -----------------------------------------------------------------------------
module mmio_uart_bridge #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mmap_sel,
  input  logic [31:0] wdata,
  input  logic        inst_retire,
  output logic [31:0] mmio_rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam logic [FCNT_W-1:0] DEPTH_C = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    SEL_CTRL  = 3'd0,
    SEL_RX    = 3'd1,
    SEL_TX    = 3'd2,
    SEL_CYC   = 3'd3,
    SEL_INSTR = 3'd4,
    SEL_CLR   = 3'd5,
    SEL_IDLE6 = 3'd6,
    SEL_IDLE7 = 3'd7
  } mmap_sel_e;

  mmap_sel_e sel;
  assign sel = mmap_sel_e'(mmap_sel);

  // Only the TX byte lane of the store data is used.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]        tx_mem [FIFO_DEPTH];
  logic [7:0]        rx_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [PTR_W-1:0]  rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [FCNT_W-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;
  logic              tx_ovf_q, tx_ovf_d;
  logic [31:0]       mmio_rdata_q, mmio_rdata_d;

  // ---------------------------------------------------------------------------
  // Handshakes: driven only from the count registers
  // ---------------------------------------------------------------------------
  logic tx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop, cnt_clr;

  assign tx_full       = (tx_count_q == DEPTH_C);
  assign rx_empty      = (rx_count_q == '0);
  assign uart_tx_valid = (tx_count_q != '0);
  assign uart_rx_ready = (rx_count_q != DEPTH_C);
  // Masked so a stale array entry never shows on the port while empty.
  assign uart_tx_data  = uart_tx_valid ? tx_mem[tx_rd_ptr_q] : 8'h00;

  // A TX write while full is dropped even if a pop happens on the same edge.
  assign tx_push = (sel == SEL_TX) && !tx_full;
  assign tx_pop  = uart_tx_valid && uart_tx_ready;
  assign rx_push = uart_rx_valid && uart_rx_ready;
  assign rx_pop  = (sel == SEL_RX) && !rx_empty;
  assign cnt_clr = (sel == SEL_CLR);

  // Counter clear wins over the same-cycle increment.
  assign cycle_cnt_d = cnt_clr ? '0 : cycle_cnt_q + CNT_W'(1);
  assign instr_cnt_d = cnt_clr ? '0 : instr_cnt_q + CNT_W'(inst_retire);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    tx_wr_ptr_d  = tx_push ? tx_wr_ptr_q + PTR_W'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d  = tx_pop  ? tx_rd_ptr_q + PTR_W'(1) : tx_rd_ptr_q;
    rx_wr_ptr_d  = rx_push ? rx_wr_ptr_q + PTR_W'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d  = rx_pop  ? rx_rd_ptr_q + PTR_W'(1) : rx_rd_ptr_q;
    tx_count_d   = tx_count_q;
    rx_count_d   = rx_count_q;
    tx_ovf_d     = tx_ovf_q;
    mmio_rdata_d = 32'h0;

    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + FCNT_W'(1);
      2'b01:   tx_count_d = tx_count_q - FCNT_W'(1);
      default: tx_count_d = tx_count_q;
    endcase

    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + FCNT_W'(1);
      2'b01:   rx_count_d = rx_count_q - FCNT_W'(1);
      default: rx_count_d = rx_count_q;
    endcase

    if (cnt_clr)
      tx_ovf_d = 1'b0;
    else if ((sel == SEL_TX) && tx_full)
      tx_ovf_d = 1'b1;

    // Read data is taken from pre-edge state.
    case (sel)
      SEL_CTRL:  mmio_rdata_d = {29'b0, tx_ovf_q, !rx_empty, !tx_full};
      SEL_RX:    mmio_rdata_d = rx_empty ? 32'h0 : {24'b0, rx_mem[rx_rd_ptr_q]};
      SEL_CYC:   mmio_rdata_d = 32'(cycle_cnt_q);
      SEL_INSTR: mmio_rdata_d = 32'(instr_cnt_q);
      default:   mmio_rdata_d = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage arrays have no reset; an entry is only ever observed
  // after it has been written, because reads are gated by the counts.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= wdata[7:0];
    if (rx_push) rx_mem[rx_wr_ptr_q] <= uart_rx_data;
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_ptr_q  <= '0;
      tx_rd_ptr_q  <= '0;
      rx_wr_ptr_q  <= '0;
      rx_rd_ptr_q  <= '0;
      tx_count_q   <= '0;
      rx_count_q   <= '0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
      tx_ovf_q     <= 1'b0;
      mmio_rdata_q <= 32'h0;
    end else begin
      tx_wr_ptr_q  <= tx_wr_ptr_d;
      tx_rd_ptr_q  <= tx_rd_ptr_d;
      rx_wr_ptr_q  <= rx_wr_ptr_d;
      rx_rd_ptr_q  <= rx_rd_ptr_d;
      tx_count_q   <= tx_count_d;
      rx_count_q   <= rx_count_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
      tx_ovf_q     <= tx_ovf_d;
      mmio_rdata_q <= mmio_rdata_d;
    end
  end

  assign mmio_rdata = mmio_rdata_q;

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart_bridge
//
// Directed scenarios followed by a randomized run against a queue-based model
// of the MMIO bridge.
// -----------------------------------------------------------------------------
module tb_mmio_uart_bridge;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic [2:0]  mmap_sel;
  logic [31:0] wdata;
  logic        inst_retire;
  logic [31:0] mmio_rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  mmio_uart_bridge #(.FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .mmap_sel      (mmap_sel),
    .wdata         (wdata),
    .inst_retire   (inst_retire),
    .mmio_rdata    (mmio_rdata),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next one.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    mmap_sel      = 3'd6;
    wdata         = 32'h0;
    inst_retire   = 1'b0;
    uart_tx_ready = 1'b0;
    uart_rx_data  = 8'h00;
    uart_rx_valid = 1'b0;
  endtask

  // Reference model: byte queues plus plain counters.
  logic [7:0]  m_txq [$];
  logic [7:0]  m_rxq [$];
  logic [31:0] m_cyc;
  logic [31:0] m_instr;
  logic        m_ovf;
  logic [31:0] m_rdata;

  // Applies one clock edge to the model given the inputs currently driven.
  task automatic model_edge();
    int tx_n = m_txq.size();
    int rx_n = m_rxq.size();
    case (mmap_sel)
      3'd0: m_rdata = {29'b0, m_ovf, rx_n != 0, tx_n != DEPTH};
      3'd1: m_rdata = (rx_n > 0) ? {24'b0, m_rxq[0]} : 32'h0;
      3'd3: m_rdata = m_cyc;
      3'd4: m_rdata = m_instr;
      default: m_rdata = 32'h0;
    endcase
    if (tx_n != 0 && uart_tx_ready) void'(m_txq.pop_front());
    if (mmap_sel == 3'd2) begin
      if (tx_n < DEPTH) m_txq.push_back(wdata[7:0]);
      else m_ovf = 1'b1;
    end
    if (mmap_sel == 3'd1 && rx_n > 0) void'(m_rxq.pop_front());
    if (uart_rx_valid && rx_n != DEPTH) m_rxq.push_back(uart_rx_data);
    if (mmap_sel == 3'd5) begin
      m_cyc   = 32'h0;
      m_instr = 32'h0;
      m_ovf   = 1'b0;
    end else begin
      m_cyc   = m_cyc + 32'd1;
      m_instr = m_instr + {31'b0, inst_retire};
    end
  endtask

  initial begin
    logic [31:0] exp_tx_data;

    idle_inputs();
    rst = 1'b0;

    // ---- reset state --------------------------------------------------------
    #3;
    check("rst_rdata",    mmio_rdata,           32'h0);
    check("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("rst_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    check("rst_tx_data",  {24'b0, uart_tx_data},  32'h0);
    @(negedge clk);
    rst = 1'b1;

    // ---- idle 10 cycles, then cycle-count read ----------------------------------
    repeat (10) step();
    mmap_sel = 3'd3;
    step();
    check("cyc_after_10", mmio_rdata, 32'd10);
    check("cyc_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("cyc_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    mmap_sel = 3'd6;

    // ---- TX fill past full, CTRL read, drain ----------------------------------------
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mmap_sel = 3'd2;
      wdata    = 32'hABCD_0041 + 32'(i);
      step();
    end
    mmap_sel = 3'd0;
    step();
    check("tx_full_ctrl", mmio_rdata, 32'h4);
    check("tx_full_head", {24'b0, uart_tx_data}, 32'h41);
    mmap_sel      = 3'd6;
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx_drain_valid%0d", i), {31'b0, uart_tx_valid}, 32'h1);
      check($sformatf("tx_drain_data%0d", i),  {24'b0, uart_tx_data},  32'h41 + 32'(i));
      step();
    end
    check("tx_drained_valid", {31'b0, uart_tx_valid}, 32'h0);
    uart_tx_ready = 1'b0;

    // ---- RX push three bytes, read four times --------------------------------------
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h10; step();
    uart_rx_data  = 8'h20; step();
    uart_rx_data  = 8'h30; step();
    uart_rx_valid = 1'b0;
    mmap_sel = 3'd0; step();
    check("rx_ctrl_bit1_before", {31'b0, mmio_rdata[1]}, 32'h1);
    mmap_sel = 3'd1; step();
    check("rx_read0", mmio_rdata, 32'h10);
    step();
    check("rx_read1", mmio_rdata, 32'h20);
    step();
    check("rx_read2", mmio_rdata, 32'h30);
    mmap_sel = 3'd0; step();
    check("rx_ctrl_bit1_after", {31'b0, mmio_rdata[1]}, 32'h0);
    mmap_sel = 3'd1; step();
    check("rx_read_empty", mmio_rdata, 32'h0);

    // ---- retire pulses with counter clear on the third ------------------------------
    for (int i = 0; i < 5; i++) begin
      inst_retire = 1'b1;
      mmap_sel    = (i == 2) ? 3'd5 : 3'd6;
      step();
    end
    inst_retire = 1'b0;
    mmap_sel = 3'd4; step();
    check("instr_after_clr", mmio_rdata, 32'd2);
    mmap_sel = 3'd3; step();
    check("cyc_after_clr", mmio_rdata, 32'd3);
    mmap_sel = 3'd0; step();
    check("ctrl_ovf_cleared", mmio_rdata, 32'h1);

    // ---- cycle counter wrap ---------------------------------------------------------
    mmap_sel = 3'd6;
    force dut.cycle_cnt_d = 32'hFFFF_FFFE;
    step();
    release dut.cycle_cnt_d;
    mmap_sel = 3'd3;
    step();
    check("wrap_read0", mmio_rdata, 32'hFFFF_FFFE);
    step();
    check("wrap_read1", mmio_rdata, 32'hFFFF_FFFF);
    step();
    check("wrap_read2", mmio_rdata, 32'h0);
    mmap_sel = 3'd6;

    // ---- asynchronous reset with TX bytes pending -------------------------------
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mmap_sel = 3'd2;
      wdata    = 32'hA1 + 32'(i);
      step();
    end
    mmap_sel = 3'd6;
    check("pre_rst_tx_valid", {31'b0, uart_tx_valid}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("async_rst_tx_data",  {24'b0, uart_tx_data},  32'h0);
    @(negedge clk);
    rst           = 1'b1;
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("post_rst_no_tx%0d", i), {31'b0, uart_tx_valid}, 32'h0);
    end

    // ---- randomized run against the model -------------------------------------------
    idle_inputs();
    rst = 1'b0;
    #1;
    m_txq.delete();
    m_rxq.delete();
    m_cyc   = 32'h0;
    m_instr = 32'h0;
    m_ovf   = 1'b0;
    m_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 400; i++) begin
      mmap_sel      = 3'($urandom_range(0, 7));
      wdata         = $urandom;
      inst_retire   = 1'($urandom_range(0, 1));
      uart_rx_data  = 8'($urandom);
      // First half leans towards filling both FIFOs, second half towards draining.
      if (i < 200) begin
        uart_tx_ready = ($urandom_range(0, 3) == 0);
        uart_rx_valid = ($urandom_range(0, 3) != 0);
      end else begin
        uart_tx_ready = ($urandom_range(0, 3) != 0);
        uart_rx_valid = ($urandom_range(0, 3) == 0);
      end
      model_edge();
      step();
      exp_tx_data = (m_txq.size() != 0) ? {24'b0, m_txq[0]} : 32'h0;
      check($sformatf("rnd%0d_rdata", i),    mmio_rdata, m_rdata);
      check($sformatf("rnd%0d_tx_valid", i), {31'b0, uart_tx_valid}, {31'b0, m_txq.size() != 0});
      check($sformatf("rnd%0d_tx_data", i),  {24'b0, uart_tx_data}, exp_tx_data);
      check($sformatf("rnd%0d_rx_ready", i), {31'b0, uart_rx_ready}, {31'b0, m_rxq.size() != DEPTH});
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
